// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types, key map and helpers for the keypad scanner
// Matrix geometry, key-code constants, frame/FSM enums and code helpers.
package keypad_pkg;

  localparam int NROWS = 4;
  localparam int NCOLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_res_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_PRESSED
  } state_e;

  function automatic logic [9:0] onehot10(input logic [3:0] code);
    return (code <= 4'd9) ? (10'd1 << code) : 10'd0;
  endfunction

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', 0, '#'.
  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - tenkey output bundle from the scanner to the lock controller
// The scanner drives the master side; consumers use the slave side.
interface keypad_scanner_if;

  logic [9:0] tenkey;
  logic [3:0] key_code;
  logic       key_held;
  logic       key_valid;

  modport master (
    output tenkey,
    output key_code,
    output key_held,
    output key_valid
  );

  modport slave (
    input tenkey,
    input key_code,
    input key_held,
    input key_valid
  );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// rtl/keypad_scanner_sync_2ff.sv - two-flop synchronizer for asynchronous inputs
// RESET_VAL lets active-low inputs come out of reset in their inactive state.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix scanner with frame-based debounce
// Scans one column per dwell period, classifies each frame, and debounces single keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_DWELL       = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NROWS-1:0] row_n,
  output logic [NCOLS-1:0] col_n,
  keypad_scanner_if.master tk
);

  localparam int DW = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
  localparam logic [CW-1:0] DB_LIMIT   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [NROWS-1:0] row_sync;
  logic [DW-1:0]    dwell_q;
  logic [1:0]       col_q;
  logic [NCOLS-1:0] col_n_q;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic             sample, frame_end;
  logic [2:0]       n_act;
  logic [1:0]       r_idx;
  frame_res_e       fr;

  state_e           state_q;
  logic [3:0]       cand_q;
  logic [CW-1:0]    cnt_q, rel_q, cnt_inc, rel_inc;
  logic [9:0]       tenkey_q;
  logic [3:0]       key_code_q;
  logic             key_held_q;
  logic             key_valid_q;

  sync_2ff #(
    .WIDTH    (NROWS),
    .RESET_VAL({NROWS{1'b1}})
  ) u_row_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (row_n),
    .q_o  (row_sync)
  );

  assign sample    = (dwell_q == DWELL_LAST);
  assign frame_end = sample && (col_q == 2'd2);

  always_comb begin
    n_act = '0;
    r_idx = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (!row_sync[r]) begin
        n_act = n_act + 3'd1;
        r_idx = 2'(r);
      end
    end
  end

  // acc_cnt saturates at 2 (= multi); the column-2 sample is folded in combinationally.
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    fr         = FR_NONE;
    if (n_act >= 3'd2 || (n_act == 3'd1 && acc_cnt_q != 2'd0)) begin
      acc_cnt_d = 2'd2;
    end else if (n_act == 3'd1) begin
      acc_cnt_d  = 2'd1;
      acc_code_d = key_at(r_idx, col_q);
    end
    if (acc_cnt_d == 2'd1) begin
      fr = FR_SINGLE;
    end else if (acc_cnt_d == 2'd2) begin
      fr = FR_MULTI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q    <= '0;
      col_q      <= '0;
      col_n_q    <= 3'b110;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (sample) begin
      dwell_q <= '0;
      if (col_q == 2'd2) begin
        col_q      <= '0;
        col_n_q    <= 3'b110;
        acc_cnt_q  <= '0;
        acc_code_q <= '0;
      end else begin
        col_q      <= col_q + 2'd1;
        col_n_q    <= {col_n_q[1:0], 1'b1};
        acc_cnt_q  <= acc_cnt_d;
        acc_code_q <= acc_code_d;
      end
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  assign cnt_inc = (cnt_q == DB_LIMIT) ? cnt_q : cnt_q + CNT_ONE;
  assign rel_inc = (rel_q == DB_LIMIT) ? rel_q : rel_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      tenkey_q    <= '0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end) begin
        unique case (state_q)
          ST_IDLE: begin
            if (fr == FR_SINGLE) begin
              cand_q <= acc_code_d;
              cnt_q  <= CNT_ONE;
              rel_q  <= '0;
              if (DEBOUNCE_FRAMES == 1) begin
                state_q     <= ST_PRESSED;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                key_code_q  <= acc_code_d;
                tenkey_q    <= onehot10(acc_code_d);
              end else begin
                state_q <= ST_CAND;
              end
            end
          end
          ST_CAND: begin
            if (fr == FR_SINGLE && acc_code_d == cand_q) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == DB_LIMIT) begin
                state_q     <= ST_PRESSED;
                rel_q       <= '0;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                key_code_q  <= cand_q;
                tenkey_q    <= onehot10(cand_q);
              end
            end else if (fr == FR_SINGLE) begin
              cand_q <= acc_code_d;
              cnt_q  <= CNT_ONE;
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          ST_PRESSED: begin
            if (fr == FR_SINGLE && acc_code_d == cand_q) begin
              rel_q <= '0;
            end else if (rel_inc == DB_LIMIT) begin
              state_q    <= ST_IDLE;
              cnt_q      <= '0;
              rel_q      <= '0;
              tenkey_q   <= '0;
              key_code_q <= '0;
              key_held_q <= 1'b0;
            end else begin
              rel_q <= rel_inc;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign col_n        = col_n_q;
  assign tk.tenkey    = tenkey_q;
  assign tk.key_code  = key_code_q;
  assign tk.key_held  = key_held_q;
  assign tk.key_valid = key_valid_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives a 4-row x 3-column ten-key matrix and debounces its output. It converts presses into the one-hot `tenkey[9:0]` bus and a press strobe, which the electronic-lock controller consumes. It is the producing end of the tenkey interface: it scans columns, samples rows, rejects multi-key and bouncing input, and reports one debounced key at a time. `*` and `#` are reported via `key_code` only.

Parameters:
- COL_DWELL, 4: clocks each column is driven. Rows are sampled on the last dwell cycle. Must be >= 3 to cover the synchronizer delay.
- DEBOUNCE_FRAMES, 3: consecutive identical frames needed to accept a press, and consecutive non-matching frames needed to accept a release. Must be >= 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- row_n, input, 4: matrix rows, active-low, asynchronous to clk.
- col_n, output, 3: column strobes, active-low, exactly one low at a time.
- tenkey, output, 10: one-hot held digit 0-9; all-zero for none, `*` or `#`.
- key_code, output, 4: held key code 0-11, valid while key_held=1; 0 otherwise.
- key_held, output, 1: a debounced key is currently pressed.
- key_valid, output, 1: one-cycle pulse on accepted press.

Behaviour:
- Key map (row, col):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: `*`(code 10), 0, `#`(code 11)
- Reset (async assert, sync deassert by the surrounding reset logic):
  - col_n=3'b110, column 0 driven.
  - Dwell counter and column index 0; frame accumulator cleared.
  - State IDLE; all counters 0.
  - tenkey=0, key_code=0, key_held=0, key_valid=0.
- row_n passes through a 2-flop synchronizer before any use.
- Scan:
  - col_n rotates 110 -> 101 -> 011 -> 110, each for COL_DWELL cycles.
  - Frame = 3*COL_DWELL cycles. The frame ends on the last dwell cycle of column 2.
  - On the sampling cycle of each column, count active rows and record (row, col).
- Frame result at frame end: NONE (0 keys), SINGLE(code) (exactly 1 key), MULTI (>= 2 keys). The accumulator clears for the next frame.
- FSM, evaluated only at frame end; outputs are registered and update on the next clock edge:
  - IDLE:
    - SINGLE(c): cand=c, cnt=1. If DEBOUNCE_FRAMES=1, go straight to PRESSED; otherwise go to CAND.
    - NONE/MULTI: stay.
  - CAND:
    - SINGLE(cand): cnt++. When cnt==DEBOUNCE_FRAMES, go to PRESSED: key_valid=1 for one cycle, key_held=1, key_code=cand, tenkey=onehot(cand) if cand<=9 else 0.
    - SINGLE(other): cand=other, cnt=1.
    - NONE/MULTI: go to IDLE, cnt=0.
  - PRESSED:
    - SINGLE(cand): rel=0.
    - Anything else (NONE, MULTI, different key): rel++. When rel==DEBOUNCE_FRAMES, go to IDLE and clear tenkey, key_code and key_held. No release pulse.
    - No rollover: a new key is accepted only after a full release, then a new debounce from IDLE.
- key_valid is never asserted on consecutive cycles. Minimum spacing is 2*DEBOUNCE_FRAMES frames.
- Counters saturate at DEBOUNCE_FRAMES. Widths are $clog2(DEBOUNCE_FRAMES+1) and $clog2(COL_DWELL).
- Reset mid-scan or mid-press: immediate return to reset values; no key_valid is emitted.

Latency:
- Key stable before reset release, with defaults: frames end at cycles 11, 23 and 35.
- key_valid is high during cycle 36, counting the first post-reset cycle as 0.

Decomposition:
- Package keypad_pkg:
  - NROWS=4, NCOLS=3.
  - Key code constants KEY_STAR=4'd10, KEY_HASH=4'd11.
  - Frame-result enum {FR_NONE, FR_SINGLE, FR_MULTI}.
  - FSM state enum {ST_IDLE, ST_CAND, ST_PRESSED}.
  - Function onehot10(code) returning logic [9:0].
- Sub-module sync_2ff (parameterized width) for the row_n synchronizer. Everything else stays in keypad_scanner.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-scan -> col_n=110, tenkey=0, key_held=0, key_valid=0 immediately.
- Clean press of 5 (row1 low only while col1 driven) from reset -> key_valid pulse at cycle 36, tenkey=10'b0000100000, key_code=5, key_held=1. Releasing for 3 frames -> key_held=0, tenkey=0, with no second pulse.
- Bounce: key 0 for 2 frames, 1 frame NONE, then stable -> no pulse until 3 consecutive SINGLE(0) frames, then exactly one pulse with tenkey=10'b0000000001.
- Multi-key: 1 and 9 held together for 10 frames -> key_valid never asserted, key_held=0. Releasing 9 -> press of 1 accepted after 3 frames.
- `#` press -> key_valid pulse, key_code=11, tenkey=0. Holding `#` for 50 frames -> no further pulse.
- Reset mid-CAND: rst_n low after frame 2 of a press of 7 -> no pulse. After rst_n=1 with key still held, pulse occurs 3 full frames later.
